// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage: bus width,
// reset PC, fetch-to-decode bus layout and small helpers.
package if_pkg;

    localparam int          FS_TO_DS_BUS_WD  = 65;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h1c00_0000;

    // Field offsets inside fs_to_ds_bus = {ex_adef, inst[31:0], pc[31:0]}
    localparam int BUS_PC_LSB   = 0;
    localparam int BUS_INST_LSB = 32;
    localparam int BUS_ADEF_BIT = 64;

    // Word fetch encoding on the SRAM-like interface
    localparam logic [1:0] SRAM_SIZE_WORD = 2'h2;

    // One instruction buffer entry; packing order matches the decode bus
    typedef struct packed {
        logic        ex_adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_entry_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with occupancy count and a one-cycle clear.
// Clear empties the FIFO; a push in the same cycle lands as the only entry.
// DEPTH need not be a power of two (pointers wrap explicitly).
module if_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    wr_idx;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (clear || !full || do_pop);
    assign wr_idx  = clear ? '0 : wr_ptr_q;

    // Next pointer and occupancy values
    always_comb begin
        // NOTE: every signal written here gets a value on every path (defaults first), so no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            rd_ptr_d = '0;
        end else if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        wr_ptr_d = do_push ? ptr_inc(wr_idx) : wr_idx;
        count_d  = (clear ? '0 : count_q) + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; pointers and count define validity, which keeps it a plain RAM.
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues word reads on an SRAM-like
// request/response interface, tracks in-flight addresses, buffers returned
// instructions and hands them to decode in issue order. Branch/flush
// redirects empty the buffer and drop responses of the old path.
// Optional feature macro: IF_ADEF_CHECK_EN (misaligned-PC exception entries).
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int          OUTSTANDING = 2,
    parameter int          IBUF_DEPTH  = 4,
    parameter logic [31:0] PC_RESET    = PC_RESET_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic                       br_valid,
    input  logic [31:0]                br_target,
    input  logic                       flush_valid,
    input  logic [31:0]                flush_target,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    localparam int CNT_W   = $clog2(OUTSTANDING + 1);
    localparam int IBUF_CW = $clog2(IBUF_DEPTH + 1);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   discard_cnt_q, discard_cnt_d;
    logic [CNT_W-1:0]   inflight;
    logic               pc_fifo_full, pc_fifo_empty;
    logic [31:0]        pc_head;
    logic [IBUF_CW-1:0] ibuf_count;
    logic               ibuf_full, ibuf_empty;
    fs_entry_t          ibuf_din;
    logic               ibuf_push, ibuf_pop;
    logic               redirect;
    logic [31:0]        redirect_target;
    logic               room;
    logic               accept;
    logic               pseudo_push;
    logic               resp;
    logic               live_resp;

    // Read-only word fetches
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SRAM_SIZE_WORD;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // Flush outranks branch, which outranks sequential fetch
    assign redirect        = flush_valid || br_valid;
    assign redirect_target = flush_valid ? flush_target : br_target;
    assign inst_sram_addr  = redirect ? redirect_target : fetch_pc_q;

    // Every in-flight request owns a reserved buffer slot, so the buffer
    // cannot overflow whatever the response timing.
    assign room = resetn && !pc_fifo_full && !ibuf_full
               && (int'(inflight) + int'(ibuf_count) < IBUF_DEPTH);

`ifdef IF_ADEF_CHECK_EN
    logic adef_hold_q, adef_hold_d;
    logic addr_bad;
    logic adef_stall;

    // A misaligned PC produces one exception entry instead of a request;
    // fetch then waits for the redirect the exception will cause.
    assign addr_bad      = pc_misaligned(inst_sram_addr);
    assign adef_stall    = adef_hold_q && !redirect;
    assign inst_sram_req = room && !addr_bad && !adef_stall;
    assign pseudo_push   = room && addr_bad && !adef_stall;

    // Exception-hold flag: set by a pseudo-entry, released by any redirect
    always_comb begin
        adef_hold_d = adef_hold_q;
        if (pseudo_push) begin
            adef_hold_d = 1'b1;
        end else if (redirect) begin
            adef_hold_d = 1'b0;
        end
    end

    // Exception-hold register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adef_hold_q <= 1'b0;
        end else begin
            adef_hold_q <= adef_hold_d;
        end
    end
`else
    assign inst_sram_req = room;
    assign pseudo_push   = 1'b0;
`endif

    assign accept = inst_sram_req && inst_sram_addr_ok;

    // A response is live only on the current path: nothing left to drop and
    // no redirect in this very cycle.
    assign resp      = inst_sram_data_ok && !pc_fifo_empty;
    assign live_resp = resp && (discard_cnt_q == '0) && !redirect;

    // Fetch PC and discard counter next state
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        discard_cnt_d = discard_cnt_q;

        if (accept || pseudo_push) begin
            fetch_pc_d = inst_sram_addr + 32'd4;
        end else if (redirect) begin
            fetch_pc_d = redirect_target;
        end

        // On redirect every older request becomes stale: the live ones plus
        // those already marked, less the response consumed this cycle.
        // A request accepted this cycle is on the new path and not counted.
        if (redirect) begin
            discard_cnt_d = inflight - CNT_W'(resp);
        end else if (resp && (discard_cnt_q != '0)) begin
            discard_cnt_d = discard_cnt_q - 1'b1;
        end
    end

    // Fetch PC and discard counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q    <= PC_RESET;
            discard_cnt_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Buffer entry: returned instruction, or an exception pseudo-entry
    always_comb begin
        ibuf_din = '0;
        if (live_resp) begin
            ibuf_din.pc   = pc_head;
            ibuf_din.inst = inst_sram_rdata;
        end else if (pseudo_push) begin
            ibuf_din.ex_adef = 1'b1;
            ibuf_din.pc      = inst_sram_addr;
        end
    end

    assign ibuf_push      = live_resp || pseudo_push;
    assign fs_to_ds_valid = !ibuf_empty && !redirect;
    assign ibuf_pop       = fs_to_ds_valid && ds_allowin;

    if_sync_fifo #(
        .WIDTH (32),
        .DEPTH (OUTSTANDING)
    ) u_pc_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clear  (1'b0),
        .push   (accept),
        .din    (inst_sram_addr),
        .pop    (resp),
        .dout   (pc_head),
        .full   (pc_fifo_full),
        .empty  (pc_fifo_empty),
        .count  (inflight)
    );

    if_sync_fifo #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk    (clk),
        .resetn (resetn),
        .clear  (redirect),
        .push   (ibuf_push),
        .din    (ibuf_din),
        .pop    (ibuf_pop),
        .dout   (fs_to_ds_bus),
        .full   (ibuf_full),
        .empty  (ibuf_empty),
        .count  (ibuf_count)
    );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: random SRAM latency, random decode back-pressure
// and random redirects against a path-level reference model. Expected entries
// are queued when the model predicts a fetch; a monitor pops them on delivery.
module tb_if_prefetch_stage;
    import if_pkg::*;

    localparam logic [31:0] PC0 = 32'h1c00_0000;

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic        br_valid;
    logic [31:0] br_target;
    logic        flush_valid;
    logic [31:0] flush_target;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_prefetch_stage #(
        .OUTSTANDING (2),
        .IBUF_DEPTH  (4),
        .PC_RESET    (PC0)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ds_allowin        (ds_allowin),
        .br_valid          (br_valid),
        .br_target         (br_target),
        .flush_valid       (flush_valid),
        .flush_target      (flush_target),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Stimulus knobs (percent probabilities)
    int p_addr  = 100;
    int p_data  = 100;
    int p_allow = 100;

    int cyc          = 0;
    int accept_count = 0;
    int deliv_count  = 0;

    // Reference model: expected entries on the surviving path, next fetch PC
    fs_entry_t   sb_q[$];
    logic [31:0] next_pc;
    logic [31:0] deliv_log[$];

    // SRAM model: accepted addresses and the cycle each may answer
    logic [31:0] sram_addr_q[$];
    int          sram_rdy_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [13:0] r;
        r = 14'($urandom);
        return {16'h1c00, r, 2'b00};
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, settle, update model
    task automatic cycle(input logic br, input logic [31:0] bt,
                         input logic fl, input logic [31:0] ft);
        fs_entry_t e;
        logic      acc;
        @(negedge clk);
        br_valid          = br;
        br_target         = bt;
        flush_valid       = fl;
        flush_target      = ft;
        ds_allowin        = ($urandom_range(99) < p_allow);
        inst_sram_addr_ok = ($urandom_range(99) < p_addr);
        if (sram_addr_q.size() > 0 && sram_rdy_q[0] <= cyc && $urandom_range(99) < p_data) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_word(sram_addr_q[0]);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = $urandom;
        end
        #1;
        if (fl || br) begin
            sb_q.delete();
            next_pc = fl ? ft : bt;
`ifdef IF_ADEF_CHECK_EN
            if (next_pc[1:0] != 2'b00) begin
                e.ex_adef = 1'b1;
                e.inst    = 32'h0;
                e.pc      = next_pc;
                sb_q.push_back(e);
            end
`endif
        end
`ifdef IF_ADEF_CHECK_EN
        check("no_misaligned_req", 65'(inst_sram_req && inst_sram_addr[1:0] != 2'b00), 65'd0);
`endif
        acc = inst_sram_req && inst_sram_addr_ok;
        if (acc) begin
            check("req_addr", 65'(inst_sram_addr), 65'(next_pc));
            e.ex_adef = 1'b0;
            e.inst    = mem_word(next_pc);
            e.pc      = next_pc;
            sb_q.push_back(e);
            next_pc = next_pc + 32'd4;
            sram_addr_q.push_back(inst_sram_addr);
            sram_rdy_q.push_back(cyc + 1);
            accept_count++;
        end
        if (inst_sram_data_ok) begin
            void'(sram_addr_q.pop_front());
            void'(sram_rdy_q.pop_front());
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn            = 1'b0;
        br_valid          = 1'b0;
        flush_valid       = 1'b0;
        br_target         = 32'h0;
        flush_target      = 32'h0;
        ds_allowin        = 1'b1;
        inst_sram_addr_ok = 1'b1;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        sram_addr_q.delete();
        sram_rdy_q.delete();
        sb_q.delete();
        deliv_log.delete();
        next_pc      = PC0;
        accept_count = 0;
        deliv_count  = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   65'(inst_sram_req),   65'd0);
        check("rst_valid", 65'(fs_to_ds_valid),  65'd0);
        check("const_wr",  65'(inst_sram_wr),    65'd0);
        check("const_size",65'(inst_sram_size),  65'd2);
        check("const_wstrb",65'(inst_sram_wstrb),65'd0);
        check("const_wdata",65'(inst_sram_wdata),65'd0);
        @(negedge clk);
        inst_sram_addr_ok = 1'b0;
        resetn            = 1'b1;
        #1;
        check("first_req",      65'(inst_sram_req),  65'd1);
        check("first_req_addr", 65'(inst_sram_addr), 65'(PC0));
    endtask

    // Monitor: every handshake to decode pops one expected entry
    always @(negedge clk) begin
        fs_entry_t e;
        #3;
        if (resetn && fs_to_ds_valid && ds_allowin) begin
            deliv_count++;
            deliv_log.push_back(fs_to_ds_bus[BUS_PC_LSB +: 32]);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_delivery: got pc %h expected no delivery",
                         fs_to_ds_bus[BUS_PC_LSB +: 32]);
            end else begin
                e = sb_q.pop_front();
                check("deliv_pc",   65'(fs_to_ds_bus[BUS_PC_LSB +: 32]),   65'(e.pc));
                check("deliv_inst", 65'(fs_to_ds_bus[BUS_INST_LSB +: 32]), 65'(e.inst));
                check("deliv_adef", 65'(fs_to_ds_bus[BUS_ADEF_BIT]),       65'(e.ex_adef));
            end
        end
    end

    initial begin
        int snap;
        resetn = 1'b0;
        do_reset();

        // Zero-wait SRAM: one instruction per cycle from the third cycle on
        p_addr = 100; p_data = 100; p_allow = 100;
        repeat (8) idle();
        check("zero_wait_count", 65'(deliv_count), 65'd6);
        check("zero_wait_pc0",   65'(deliv_log[0]), 65'(32'h1c00_0000));
        check("zero_wait_pc1",   65'(deliv_log[1]), 65'(32'h1c00_0004));
        check("zero_wait_pc2",   65'(deliv_log[2]), 65'(32'h1c00_0008));

        // Responses withheld: request count capped at OUTSTANDING
        do_reset();
        p_data = 0;
        repeat (6) idle();
        check("outstanding_cap", 65'(accept_count), 65'd2);
        #1;
        check("outstanding_req_low", 65'(inst_sram_req), 65'd0);
        p_data = 100;
        repeat (10) idle();

        // Decode stalled: buffer fills to 4 and fetching stops, then drains
        do_reset();
        p_allow = 0;
        repeat (10) idle();
        check("ibuf_fill_accepts", 65'(accept_count), 65'd4);
        #1;
        check("ibuf_full_req_low", 65'(inst_sram_req), 65'd0);
        check("ibuf_stall_no_deliv", 65'(deliv_count), 65'd0);
        p_allow = 100;
        repeat (10) idle();
        check("ibuf_drain", 65'(deliv_count >= 4), 65'd1);

        // Branch with two requests in flight: both responses dropped
        do_reset();
        p_data = 0;
        repeat (3) idle();
        deliv_log.delete();
        cycle(1'b1, 32'h1c00_0100, 1'b0, 32'h0);
        p_data = 100;
        repeat (10) idle();
        check("branch_first_pc", 65'(deliv_log[0]), 65'(32'h1c00_0100));

        // Flush and branch together: flush wins
        do_reset();
        repeat (4) idle();
        deliv_log.delete();
        cycle(1'b1, 32'h1c00_0200, 1'b1, 32'h1c00_8000);
        repeat (10) idle();
        check("flush_first_pc", 65'(deliv_log[0]), 65'(32'h1c00_8000));

`ifdef IF_ADEF_CHECK_EN
        // Misaligned branch target: one exception entry, no request for it
        do_reset();
        repeat (3) idle();
        deliv_log.delete();
        snap = accept_count;
        cycle(1'b1, 32'h1c00_0102, 1'b0, 32'h0);
        repeat (8) idle();
        check("adef_count",   65'(deliv_log.size()), 65'd1);
        check("adef_pc",      65'(deliv_log[0]),     65'(32'h1c00_0102));
        check("adef_no_req",  65'(accept_count),     65'(snap));
`endif

        // Random traffic, with a reset in the middle of operation
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
                int r;
                if (i % 50 == 0) begin
                    p_addr  = $urandom_range(20, 100);
                    p_data  = $urandom_range(20, 100);
                    p_allow = $urandom_range(0, 100);
                end
                r = $urandom_range(15);
                if (r == 0) begin
                    cycle(1'b1, rand_target(), 1'b0, 32'h0);
                end else if (r == 1) begin
                    cycle(1'($urandom_range(1)), rand_target(), 1'b1, rand_target());
                end else begin
                    idle();
                end
            end
            if (seg == 1) begin
                p_addr = 0; p_data = 100; p_allow = 100;
                repeat (40) idle();
                check("drain_empty", 65'(sb_q.size()), 65'd0);
            end
        end

        snap = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
